// File: rtl/alu_share_arbiter.sv
// Round-robin front end that lets two requesters share one external combinational ALU.
// One transaction is in flight at a time: accept in IDLE, sample the ALU in EXEC, hand back in RESP.
module alu_share_arbiter #(
   parameter int WIDTH = 8,
   parameter int OPW   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,
   output logic [OPW-1:0]   alu_instruction,
   output logic [WIDTH-1:0] alu_input_1,
   output logic [WIDTH-1:0] alu_input_2,
   input  logic [WIDTH-1:0] alu_output,
   output logic             busy,
   output logic             grant
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [OPW-1:0]   r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_last0;
   logic [WIDTH-1:0] r_last1;
   logic             r_grant;
   logic             w_sel;
   logic             w_anyValid;
   logic             w_accept;
   logic             w_rspHs;

   // Under contention the port that did not own the last transaction wins.
   always_comb begin
      w_anyValid = req0_valid | req1_valid;
      w_sel      = 1'b0;
      if (req0_valid && req1_valid) begin
         w_sel = ~r_grant;
      end else if (req1_valid) begin
         w_sel = 1'b1;
      end
   end

   assign req0_ready = rst && (r_state == IDLE) && w_anyValid && !w_sel;
   assign req1_ready = rst && (r_state == IDLE) && w_anyValid &&  w_sel;
   assign w_accept   = req0_ready | req1_ready;
   assign w_rspHs    = (r_state == RESP) && (r_grant ? rsp1_ready : rsp0_ready);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = EXEC;
         EXEC:    w_nextState = RESP;
         RESP:    if (w_rspHs) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Operand registers drive the ALU and only change on an accept, so it sees stable inputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_last0  <= '0;
         r_last1  <= '0;
         r_grant  <= 1'b1;
      end else begin
         if (w_accept) begin
            r_op    <= w_sel ? req1_op : req0_op;
            r_a     <= w_sel ? req1_a  : req0_a;
            r_b     <= w_sel ? req1_b  : req0_b;
            r_grant <= w_sel;
         end
         if (r_state == EXEC) begin
            r_result <= alu_output;
         end
         if (w_rspHs) begin
            if (r_grant) begin
               r_last1 <= r_result;
            end else begin
               r_last0 <= r_result;
            end
         end
      end
   end

   // The non-granted port keeps showing the last result it actually received.
   assign rsp0_valid      = (r_state == RESP) && !r_grant;
   assign rsp1_valid      = (r_state == RESP) &&  r_grant;
   assign rsp0_data       = r_grant ? r_last0  : r_result;
   assign rsp1_data       = r_grant ? r_result : r_last1;
   assign alu_instruction = r_op;
   assign alu_input_1     = r_a;
   assign alu_input_2     = r_b;
   assign busy            = (r_state != IDLE);
   assign grant           = r_grant;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a small ALU model on the shared port,
// hand-computed expected results, one task per scenario.
module tb_alu_share_arbiter;

   logic       clk;
   logic       rst;
   logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [7:0] req0_op, req0_a, req0_b, rsp0_data;
   logic [7:0] req1_op, req1_a, req1_b, rsp1_data;
   logic [7:0] alu_instruction, alu_input_1, alu_input_2, alu_output;
   logic       busy, grant;

   int checks   = 0;
   int failures = 0;

   alu_share_arbiter #(.WIDTH(8), .OPW(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .alu_instruction(alu_instruction), .alu_input_1(alu_input_1),
      .alu_input_2(alu_input_2), .alu_output(alu_output),
      .busy(busy), .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU: 0x00 OR, 0x01 NAND, 0x02 AND, 0x03 XOR, 0x04 ADD, 0x05 SUB.
   always_comb begin
      alu_output = 8'h00;
      case (alu_instruction)
         8'h00: alu_output = alu_input_1 | alu_input_2;
         8'h01: alu_output = ~(alu_input_1 & alu_input_2);
         8'h02: alu_output = alu_input_1 & alu_input_2;
         8'h03: alu_output = alu_input_1 ^ alu_input_2;
         8'h04: alu_output = alu_input_1 + alu_input_2;
         8'h05: alu_output = alu_input_1 - alu_input_2;
         default: alu_output = 8'h00;
      endcase
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req0_valid = 1'b0; req0_op = 8'h00; req0_a = 8'h00; req0_b = 8'h00;
      req1_valid = 1'b0; req1_op = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if ({busy, grant, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 6'b010000) begin
         failures++;
         $display("[TB] FAIL reset_ctrl got=%b exp=%b", {busy, grant, req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 6'b010000);
      end
      checks++;
      if ({alu_instruction, alu_input_1, alu_input_2} !== 24'h000000) begin
         failures++;
         $display("[TB] FAIL reset_alu got=%h exp=%h", {alu_instruction, alu_input_1, alu_input_2}, 24'h000000);
      end
      checks++;
      if ({rsp0_data, rsp1_data} !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL reset_data got=%h exp=%h", {rsp0_data, rsp1_data}, 16'h0000);
      end
      idle_inputs();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_port0_only;
      req0_valid = 1'b1; req0_op = 8'h04; req0_a = 8'h05; req0_b = 8'h03;
      rsp0_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL p0_ready got=%b exp=%b", {req0_ready, req1_ready}, 2'b10);
      end
      tick();
      req0_valid = 1'b0;
      #1;
      checks++;
      if ({alu_instruction, alu_input_1, alu_input_2, busy, grant, rsp0_valid} !== {24'h040503, 3'b100}) begin
         failures++;
         $display("[TB] FAIL p0_exec got=%h exp=%h", {alu_instruction, alu_input_1, alu_input_2, busy, grant, rsp0_valid}, {24'h040503, 3'b100});
      end
      tick();
      #1;
      checks++;
      if ({rsp0_valid, rsp1_valid, rsp0_data} !== {2'b10, 8'h08}) begin
         failures++;
         $display("[TB] FAIL p0_resp got=%h exp=%h", {rsp0_valid, rsp1_valid, rsp0_data}, {2'b10, 8'h08});
      end
      tick();
      #1;
      checks++;
      if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL p0_done got=%b exp=%b", {busy, rsp0_valid, rsp1_valid}, 3'b000);
      end
      checks++;
      if ({alu_input_1, alu_input_2} !== 16'h0503) begin
         failures++;
         $display("[TB] FAIL p0_alu_hold got=%h exp=%h", {alu_input_1, alu_input_2}, 16'h0503);
      end
      idle_inputs();
   endtask

   task automatic test_contention;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      req0_valid = 1'b1; req0_op = 8'h05; req0_a = 8'h03; req0_b = 8'h05;
      req1_valid = 1'b1; req1_op = 8'h01; req1_a = 8'hF0; req1_b = 8'hFF;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL cont_first got=%b exp=%b", {req0_ready, req1_ready}, 2'b10);
      end
      tick();
      req0_valid = 1'b0;
      #1;
      checks++;
      if ({grant, req1_ready} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL cont_exec0 got=%b exp=%b", {grant, req1_ready}, 2'b00);
      end
      tick();
      #1;
      checks++;
      if ({rsp0_valid, req1_ready, rsp0_data} !== {2'b10, 8'hFE}) begin
         failures++;
         $display("[TB] FAIL cont_rsp0 got=%h exp=%h", {rsp0_valid, req1_ready, rsp0_data}, {2'b10, 8'hFE});
      end
      tick();
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL cont_accept1 got=%b exp=%b", req1_ready, 1'b1);
      end
      tick();
      req1_valid = 1'b0;
      #1;
      checks++;
      if (grant !== 1'b1) begin
         failures++;
         $display("[TB] FAIL cont_grant1 got=%b exp=%b", grant, 1'b1);
      end
      tick();
      #1;
      checks++;
      if ({rsp1_valid, rsp0_valid, rsp1_data, rsp0_data} !== {2'b10, 8'h0F, 8'hFE}) begin
         failures++;
         $display("[TB] FAIL cont_rsp1 got=%h exp=%h", {rsp1_valid, rsp0_valid, rsp1_data, rsp0_data}, {2'b10, 8'h0F, 8'hFE});
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_round_robin;
      int n0;
      int n1;
      logic expPort;
      logic [7:0] expData;
      n0 = 0;
      n1 = 0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         expPort = k[0];
         req0_valid = 1'b1; req0_op = 8'h04; req0_a = 8'h20 + n0[7:0]; req0_b = 8'h01;
         req1_valid = 1'b1; req1_op = 8'h03; req1_a = 8'h40 + n1[7:0]; req1_b = 8'hFF;
         #1;
         checks++;
         if ({req1_ready, req0_ready} !== {expPort, ~expPort}) begin
            failures++;
            $display("[TB] FAIL rr_ready[%0d] got=%b exp=%b", k, {req1_ready, req0_ready}, {expPort, ~expPort});
         end
         tick();
         #1;
         checks++;
         if (grant !== expPort) begin
            failures++;
            $display("[TB] FAIL rr_grant[%0d] got=%b exp=%b", k, grant, expPort);
         end
         tick();
         #1;
         expData = expPort ? ((8'h40 + n1[7:0]) ^ 8'hFF) : (8'h21 + n0[7:0]);
         checks++;
         if ({rsp1_valid, rsp0_valid, (expPort ? rsp1_data : rsp0_data)} !== {expPort, ~expPort, expData}) begin
            failures++;
            $display("[TB] FAIL rr_rsp[%0d] got=%h exp=%h", k, {rsp1_valid, rsp0_valid, (expPort ? rsp1_data : rsp0_data)}, {expPort, ~expPort, expData});
         end
         if (expPort) n1++;
         else n0++;
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_stall;
      req1_valid = 1'b1; req1_op = 8'h02; req1_a = 8'h3C; req1_b = 8'h0F;
      rsp1_ready = 1'b0;
      tick();
      req0_valid = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({rsp1_valid, rsp1_data, req0_ready, req1_ready, busy} !== {1'b1, 8'h0C, 3'b001}) begin
            failures++;
            $display("[TB] FAIL stall[%0d] got=%h exp=%h", i, {rsp1_valid, rsp1_data, req0_ready, req1_ready, busy}, {1'b1, 8'h0C, 3'b001});
         end
         tick();
      end
      rsp1_ready = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      checks++;
      if (rsp1_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stall_last got=%b exp=%b", rsp1_valid, 1'b1);
      end
      tick();
      #1;
      checks++;
      if ({busy, rsp1_valid, rsp1_data} !== {2'b00, 8'h0C}) begin
         failures++;
         $display("[TB] FAIL stall_done got=%h exp=%h", {busy, rsp1_valid, rsp1_data}, {2'b00, 8'h0C});
      end
      idle_inputs();
   endtask

   task automatic test_reset_exec;
      req0_valid = 1'b1; req0_op = 8'h04; req0_a = 8'h11; req0_b = 8'h22;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      tick();
      req0_valid = 1'b0;
      #1;
      checks++;
      if ({busy, grant} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL rexec_pre got=%b exp=%b", {busy, grant}, 2'b10);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, grant, alu_instruction, alu_input_1, alu_input_2} !== {2'b01, 24'h000000}) begin
         failures++;
         $display("[TB] FAIL rexec_post got=%h exp=%h", {busy, grant, alu_instruction, alu_input_1, alu_input_2}, {2'b01, 24'h000000});
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         checks++;
         if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL rexec_quiet[%0d] got=%b exp=%b", i, {rsp0_valid, rsp1_valid, busy}, 3'b000);
         end
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back;
      req1_valid = 1'b1; req1_op = 8'h00; req1_a = 8'h0F; req1_b = 8'hF0;
      rsp1_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         #1;
         checks++;
         if (req1_ready !== ((c % 3) == 0)) begin
            failures++;
            $display("[TB] FAIL b2b_ready[%0d] got=%b exp=%b", c, req1_ready, ((c % 3) == 0));
         end
         if ((c % 3) == 2) begin
            checks++;
            if ({rsp1_valid, rsp0_valid, rsp1_data} !== {2'b10, 8'hFF}) begin
               failures++;
               $display("[TB] FAIL b2b_rsp[%0d] got=%h exp=%h", c, {rsp1_valid, rsp0_valid, rsp1_data}, {2'b10, 8'hFF});
            end
         end
         if (c == 8) req1_valid = 1'b0;
         tick();
      end
      #1;
      checks++;
      if ({busy, grant} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL b2b_end got=%b exp=%b", {busy, grant}, 2'b01);
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_port0_only();
      test_contention();
      test_round_robin();
      test_stall();
      test_reset_exec();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 8-bit ALU between two requesters, port 0 and port 1.
- Each requester issues an (instruction, operand A, operand B) transaction over a valid/ready handshake. It receives the ALU result on its own response channel, which also uses valid/ready.
- The block drives the external ALU's Instruction, Input_1 and Input_2 from registers. It samples the ALU's Output one cycle later.
- Arbitration between the two ports is round-robin. Only one transaction is in flight at a time.

Parameters:
- WIDTH, 8: operand and result width. This must match the ALU's data width.
- OPW, 8: instruction width. The full word is passed to the ALU unmodified.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset; synchronous, active-low (0 = reset)
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle
- req0_op  input  OPW  port 0 ALU instruction
- req0_a  input  WIDTH  port 0 operand A (to ALU Input_1)
- req0_b  input  WIDTH  port 0 operand B (to ALU Input_2)
- rsp0_valid  output  1  port 0 result valid
- rsp0_ready  input  1  port 0 result consumed
- rsp0_data  output  WIDTH  port 0 result
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data: identical set for port 1
- alu_instruction  output  OPW  to ALU Instruction
- alu_input_1  output  WIDTH  to ALU Input_1
- alu_input_2  output  WIDTH  to ALU Input_2
- alu_output  input  WIDTH  from ALU Output
- busy  output  1  high whenever state != IDLE
- grant  output  1  index of the port owning the current or last transaction

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; op, A, B and result registers cleared to 0.
  - grant=1, so port 0 wins the first contention.
  - All ready and valid outputs are 0; alu_* outputs are 0.
- Reset overrides everything. Reset mid-transaction discards that transaction and no response is ever issued for it.
- State machine has three states: IDLE, EXEC, RESP.
- IDLE, selection:
  - If exactly one reqN_valid is high, that port is selected.
  - If both are high, the port != grant is selected.
  - reqN_ready is combinational and is high only in IDLE for the selected port. The other port's ready is 0.
- IDLE, accept (handshake = valid & ready at the edge):
  - reqN_op, reqN_a and reqN_b are latched into the operand registers.
  - grant <= N; state <= EXEC.
  - With no valid request, the block stays in IDLE.
- ALU drive:
  - alu_instruction, alu_input_1 and alu_input_2 come directly from the operand registers and never from the request ports.
  - They hold their values until the next accept, including while idle.
- EXEC: lasts exactly one cycle. At its closing edge, result register <= alu_output and state <= RESP.
- RESP:
  - rsp{grant}_valid=1 and rsp{grant}_data=result register. The other port's rsp_valid=0.
  - When rsp{grant}_ready=1 at the edge, state <= IDLE.
  - Otherwise the block stalls in RESP with data held stable.
  - No request is accepted during RESP or EXEC.
- rspN_data:
  - The granted port shows the result register.
  - The non-granted port shows its last delivered result, 0 after reset.
- Latency and throughput:
  - rsp_valid rises 2 cycles after the accept edge.
  - Minimum spacing between accepts is 3 cycles (accept, EXEC, RESP with ready=1).
  - The first accept after RESP is possible in the cycle following the response handshake.
- Fairness: grant alternates under continuous two-port contention (0,1,0,1...). A single active port is served back-to-back with no penalty.
- A request valid dropped before acceptance has no effect. Requests are not queued.
- Width rules: no arithmetic is performed in this block. Operands and results are passed through bit-exact at WIDTH bits.

Test Plan:
1. Port 0 only: op=0x04 (ADD), a=0x05, b=0x03, rsp0_ready=1.
   -> req0_ready=1 in cycle 0; alu_input_1=0x05 and alu_input_2=0x03 in cycle 1; rsp0_valid=1 with rsp0_data=0x08 in cycle 2; rsp1_valid stays 0.
2. Both ports valid after reset: port 0 op=0x05 (SUB) a=0x03 b=0x05; port 1 op=0x01 (NAND) a=0xF0 b=0xFF.
   -> port 0 is served first, rsp0_data=0xFE; port 1 is accepted in the cycle after rsp0's handshake, rsp1_data=0x0F; grant reads 0 then 1.
3. Continuous contention on both ports for 6 transactions.
   -> grant sequence is 0,1,0,1,0,1; each port receives 3 responses in order.
4. rsp1_ready held 0 for 5 cycles during RESP.
   -> rsp1_valid=1 and rsp1_data stay constant; both req*_ready=0; busy=1; completion happens on the cycle rsp1_ready rises.
5. rst=0 asserted in EXEC.
   -> the next cycle shows state IDLE, busy=0, alu_* outputs 0, grant=1, and no rsp_valid pulse ever appears for the dropped transaction.
6. Port 1 issues 3 back-to-back requests (op=0x00 OR, a=0x0F, b=0xF0) with port 0 idle.
   -> three accepts 3 cycles apart, each giving rsp1_data=0xFF.
